// File: rtl/cpu_bus_responder.sv
// CPU bus responder: decodes CPU strobes into internal RAM, external memory or open-bus accesses.
// Latency: IRAM 1 cycle, EXT until MEM_ACK or TIMEOUT cycles; WAITB stalls the CPU only while EXT is pending.
module cpu_bus_responder #(
    parameter logic [15:0] IRAM_BASE = 16'hFF80,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CP1_POSEDGE,
    input  logic [15:0] A,
    input  logic [7:0]  DB_O,
    input  logic        RDB,
    input  logic        WRB,
    output logic [7:0]  DB_I,
    output logic        WAITB,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [1:0]  MEM_SEL,
    output logic [14:0] MEM_A,
    output logic [7:0]  MEM_DO,
    input  logic [7:0]  MEM_DI,
    input  logic        MEM_ACK
);

    typedef enum logic [1:0] {ST_IDLE, ST_IRAM, ST_EXT, ST_HOLD} state_t;
    typedef enum logic [1:0] {RG_IRAM, RG_EXT, RG_OPEN} region_t;

    localparam logic [16:0] IRAM_LO  = {1'b0, IRAM_BASE};
    localparam logic [16:0] IRAM_HI  = {1'b0, IRAM_BASE} + 17'd127;
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    region_t     region;
    logic [1:0]  dec_sel;
    logic [14:0] dec_off;
    logic        start;
    logic        tmo_hit;

    logic [7:0]  db_i_q;
    logic [7:0]  cnt;
    logic        wr_q;
    logic [1:0]  sel_q;
    logic [14:0] off_q;
    logic [7:0]  wdat_q;
    logic [6:0]  iaddr_q;
    logic [7:0]  ram [128];

    // Every external region offset is A[14:0] except VRAM, which sits at 0x2000.
    always_comb begin
        region  = RG_OPEN;
        dec_sel = 2'd0;
        dec_off = A[14:0];
        if (({1'b0, A} >= IRAM_LO) && ({1'b0, A} <= IRAM_HI)) begin
            region = RG_IRAM;
        end else if (A <= 16'h0FFF) begin
            region  = RG_EXT;
            dec_sel = 2'd0;
        end else if ((A >= 16'h2000) && (A <= 16'h3FFF)) begin
            region  = RG_EXT;
            dec_sel = 2'd1;
            dec_off = A[14:0] - 15'h2000;
        end else if ((A >= 16'h8000) && (A < IRAM_BASE)) begin
            region  = RG_EXT;
            dec_sel = 2'd2;
        end
    end

    assign start   = CP1_POSEDGE && (RDB != WRB) && (state == ST_IDLE);
    assign tmo_hit = (cnt == TMO_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (region)
                        RG_IRAM: state_nxt = ST_IRAM;
                        RG_EXT:  state_nxt = ST_EXT;
                        default: state_nxt = ST_HOLD;
                    endcase
                end
            end
            ST_IRAM: state_nxt = ST_HOLD;
            ST_EXT:  if (MEM_ACK || tmo_hit) state_nxt = ST_HOLD;
            ST_HOLD: if (RDB && WRB) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        MEM_REQ = 1'b0;
        MEM_WE  = 1'b0;
        WAITB   = 1'b1;
        if (state == ST_EXT) begin
            MEM_REQ = 1'b1;
            MEM_WE  = wr_q;
            WAITB   = 1'b0;
        end
    end

    assign DB_I    = db_i_q;
    assign MEM_SEL = sel_q;
    assign MEM_A   = off_q;
    assign MEM_DO  = wdat_q;

    // Read data is captured at the start edge for IRAM/OPEN so it is valid the next cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            db_i_q  <= 8'hFF;
            cnt     <= 8'd0;
            wr_q    <= 1'b0;
            sel_q   <= 2'd0;
            off_q   <= 15'd0;
            wdat_q  <= 8'd0;
            iaddr_q <= 7'd0;
        end else begin
            if (start) begin
                wr_q    <= !WRB;
                sel_q   <= dec_sel;
                off_q   <= dec_off;
                wdat_q  <= DB_O;
                iaddr_q <= A[6:0];
                cnt     <= 8'd0;
                if (!RDB) begin
                    if (region == RG_IRAM) begin
                        db_i_q <= ram[A[6:0]];
                    end else if (region == RG_OPEN) begin
                        db_i_q <= 8'hFF;
                    end
                end
            end
            if (state == ST_EXT) begin
                cnt <= cnt + 8'd1;
                if (MEM_ACK) begin
                    if (!wr_q) db_i_q <= MEM_DI;
                end else if (tmo_hit) begin
                    db_i_q <= 8'hFF;
                end
            end
        end
    end

    // IRAM contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (!RESET && (state == ST_IRAM) && wr_q) begin
            ram[iaddr_q] <= wdat_q;
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: IRAM, external read/write/timeout, decode, open bus, reset.
module tb_cpu_bus_responder;

    logic        CLK;
    logic        RESET;
    logic        CP1_POSEDGE;
    logic [15:0] A;
    logic [7:0]  DB_O;
    logic        RDB;
    logic        WRB;
    logic [7:0]  DB_I;
    logic        WAITB;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [1:0]  MEM_SEL;
    logic [14:0] MEM_A;
    logic [7:0]  MEM_DO;
    logic [7:0]  MEM_DI;
    logic        MEM_ACK;

    int checks = 0;
    int passed = 0;
    int req_cycles = 0;
    int req_starts = 0;
    logic req_prev = 1'b0;

    cpu_bus_responder #(.IRAM_BASE(16'hFF80), .TIMEOUT(4)) dut (
        .CLK(CLK), .RESET(RESET), .CP1_POSEDGE(CP1_POSEDGE), .A(A), .DB_O(DB_O),
        .RDB(RDB), .WRB(WRB), .DB_I(DB_I), .WAITB(WAITB), .MEM_REQ(MEM_REQ),
        .MEM_WE(MEM_WE), .MEM_SEL(MEM_SEL), .MEM_A(MEM_A), .MEM_DO(MEM_DO),
        .MEM_DI(MEM_DI), .MEM_ACK(MEM_ACK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (MEM_REQ) req_cycles++;
        if (MEM_REQ && !req_prev) req_starts++;
        req_prev = MEM_REQ;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_acc(input logic rd, input logic [15:0] addr, input logic [7:0] dat);
        A = addr; DB_O = dat; RDB = !rd; WRB = rd; CP1_POSEDGE = 1'b1;
        tick();
        CP1_POSEDGE = 1'b0;
    endtask

    task automatic release_bus();
        RDB = 1'b1; WRB = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        checks++; if (MEM_REQ !== 1'b0) $display("FAIL reset_req: got %b want 0", MEM_REQ); else passed++;
        checks++; if (MEM_WE !== 1'b0) $display("FAIL reset_we: got %b want 0", MEM_WE); else passed++;
        checks++; if (WAITB !== 1'b1) $display("FAIL reset_waitb: got %b want 1", WAITB); else passed++;
        checks++; if (DB_I !== 8'hFF) $display("FAIL reset_dbi: got %h want ff", DB_I); else passed++;
        checks++; if (dut.state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dut.state); else passed++;
        checks++; if (dut.cnt !== 8'd0) $display("FAIL reset_cnt: got %0d want 0", dut.cnt); else passed++;
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_iram();
        req_cycles = 0;
        start_acc(1'b0, 16'hFF85, 8'h5A);
        checks++; if (WAITB !== 1'b1) $display("FAIL iram_wr_waitb: got %b want 1", WAITB); else passed++;
        release_bus();
        start_acc(1'b0, 16'hFF80, 8'hA1);
        release_bus();
        start_acc(1'b0, 16'hFFFF, 8'hB2);
        release_bus();
        start_acc(1'b1, 16'hFF85, 8'h00);
        checks++; if (DB_I !== 8'h5A) $display("FAIL iram_rd_ff85: got %h want 5a", DB_I); else passed++;
        tick();
        checks++; if (DB_I !== 8'h5A) $display("FAIL iram_rd_hold: got %h want 5a", DB_I); else passed++;
        checks++; if (dut.state !== 2'd3) $display("FAIL iram_hold_state: got %0d want 3", dut.state); else passed++;
        release_bus();
        start_acc(1'b1, 16'hFF80, 8'h00);
        checks++; if (DB_I !== 8'hA1) $display("FAIL iram_rd_ff80: got %h want a1", DB_I); else passed++;
        release_bus();
        start_acc(1'b1, 16'hFFFF, 8'h00);
        checks++; if (DB_I !== 8'hB2) $display("FAIL iram_rd_ffff: got %h want b2", DB_I); else passed++;
        release_bus();
        checks++; if (req_cycles !== 0) $display("FAIL iram_no_req: got %0d req cycles want 0", req_cycles); else passed++;
    endtask

    task automatic test_ext_read();
        req_cycles = 0;
        start_acc(1'b1, 16'h2010, 8'h00);
        checks++; if (MEM_REQ !== 1'b1) $display("FAIL extrd_req: got %b want 1", MEM_REQ); else passed++;
        checks++; if (WAITB !== 1'b0) $display("FAIL extrd_waitb: got %b want 0", WAITB); else passed++;
        checks++; if (MEM_SEL !== 2'd1) $display("FAIL extrd_sel: got %0d want 1", MEM_SEL); else passed++;
        checks++; if (MEM_A !== 15'h0010) $display("FAIL extrd_addr: got %h want 0010", MEM_A); else passed++;
        checks++; if (MEM_WE !== 1'b0) $display("FAIL extrd_we: got %b want 0", MEM_WE); else passed++;
        tick();
        tick();
        MEM_DI = 8'hC3; MEM_ACK = 1'b1;
        checks++; if (MEM_A !== 15'h0010) $display("FAIL extrd_addr_stable: got %h want 0010", MEM_A); else passed++;
        tick();
        MEM_ACK = 1'b0; MEM_DI = 8'h00;
        checks++; if (DB_I !== 8'hC3) $display("FAIL extrd_data: got %h want c3", DB_I); else passed++;
        checks++; if (WAITB !== 1'b1) $display("FAIL extrd_waitb_done: got %b want 1", WAITB); else passed++;
        checks++; if (MEM_REQ !== 1'b0) $display("FAIL extrd_req_done: got %b want 0", MEM_REQ); else passed++;
        checks++; if (req_cycles !== 3) $display("FAIL extrd_req_len: got %0d want 3", req_cycles); else passed++;
        release_bus();
    endtask

    task automatic test_ext_timeout();
        req_cycles = 0;
        start_acc(1'b0, 16'h9000, 8'h11);
        checks++; if (MEM_SEL !== 2'd2) $display("FAIL tmo_sel: got %0d want 2", MEM_SEL); else passed++;
        checks++; if (MEM_A !== 15'h1000) $display("FAIL tmo_addr: got %h want 1000", MEM_A); else passed++;
        checks++; if (MEM_WE !== 1'b1) $display("FAIL tmo_we: got %b want 1", MEM_WE); else passed++;
        checks++; if (MEM_DO !== 8'h11) $display("FAIL tmo_do: got %h want 11", MEM_DO); else passed++;
        tick();
        tick();
        tick();
        checks++; if (MEM_REQ !== 1'b1) $display("FAIL tmo_req_last: got %b want 1", MEM_REQ); else passed++;
        tick();
        checks++; if (MEM_REQ !== 1'b0) $display("FAIL tmo_req_drop: got %b want 0", MEM_REQ); else passed++;
        checks++; if (WAITB !== 1'b1) $display("FAIL tmo_waitb: got %b want 1", WAITB); else passed++;
        checks++; if (DB_I !== 8'hFF) $display("FAIL tmo_dbi: got %h want ff", DB_I); else passed++;
        checks++; if (req_cycles !== 4) $display("FAIL tmo_req_len: got %0d want 4", req_cycles); else passed++;
        release_bus();
    endtask

    task automatic test_ack_priority();
        req_cycles = 0;
        start_acc(1'b1, 16'h0ABC, 8'h00);
        tick();
        tick();
        tick();
        MEM_DI = 8'h3C; MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0; MEM_DI = 8'h00;
        checks++; if (DB_I !== 8'h3C) $display("FAIL prio_data: got %h want 3c", DB_I); else passed++;
        checks++; if (req_cycles !== 4) $display("FAIL prio_req_len: got %0d want 4", req_cycles); else passed++;
        release_bus();
    endtask

    task automatic test_decode();
        logic [15:0] t_a   [10];
        logic        t_ext [10];
        logic [1:0]  t_sel [10];
        logic [14:0] t_off [10];
        t_a[0] = 16'h0000; t_ext[0] = 1; t_sel[0] = 0; t_off[0] = 15'h0000;
        t_a[1] = 16'h0FFF; t_ext[1] = 1; t_sel[1] = 0; t_off[1] = 15'h0FFF;
        t_a[2] = 16'h1000; t_ext[2] = 0; t_sel[2] = 0; t_off[2] = 15'h0000;
        t_a[3] = 16'h2000; t_ext[3] = 1; t_sel[3] = 1; t_off[3] = 15'h0000;
        t_a[4] = 16'h3FFF; t_ext[4] = 1; t_sel[4] = 1; t_off[4] = 15'h1FFF;
        t_a[5] = 16'h4000; t_ext[5] = 0; t_sel[5] = 0; t_off[5] = 15'h0000;
        t_a[6] = 16'h7F80; t_ext[6] = 0; t_sel[6] = 0; t_off[6] = 15'h0000;
        t_a[7] = 16'h1800; t_ext[7] = 0; t_sel[7] = 0; t_off[7] = 15'h0000;
        t_a[8] = 16'h8000; t_ext[8] = 1; t_sel[8] = 2; t_off[8] = 15'h0000;
        t_a[9] = 16'hFF7F; t_ext[9] = 1; t_sel[9] = 2; t_off[9] = 15'h7F7F;
        for (int i = 0; i < 10; i++) begin
            start_acc(1'b1, t_a[i], 8'h00);
            checks++; if (MEM_REQ !== t_ext[i]) $display("FAIL dec_req[%0d]: got %b want %b", i, MEM_REQ, t_ext[i]); else passed++;
            if (t_ext[i]) begin
                checks++; if (MEM_SEL !== t_sel[i]) $display("FAIL dec_sel[%0d]: got %0d want %0d", i, MEM_SEL, t_sel[i]); else passed++;
                checks++; if (MEM_A !== t_off[i]) $display("FAIL dec_off[%0d]: got %h want %h", i, MEM_A, t_off[i]); else passed++;
            end
            // For OPEN this ack lands in HOLD and must be ignored.
            MEM_DI = 8'h40 + 8'(i); MEM_ACK = 1'b1;
            tick();
            MEM_ACK = 1'b0;
            checks++;
            if (DB_I !== (t_ext[i] ? 8'h40 + 8'(i) : 8'hFF)) $display("FAIL dec_dbi[%0d]: got %h want %h", i, DB_I, t_ext[i] ? 8'h40 + 8'(i) : 8'hFF);
            else passed++;
            release_bus();
        end
    endtask

    task automatic test_open_and_both_low();
        req_cycles = 0;
        A = 16'h2000; RDB = 1'b0; WRB = 1'b0; CP1_POSEDGE = 1'b1;
        tick();
        CP1_POSEDGE = 1'b0;
        checks++; if (dut.state !== 2'd0) $display("FAIL both_low_state: got %0d want 0", dut.state); else passed++;
        release_bus();
        start_acc(1'b0, 16'h4000, 8'h99);
        release_bus();
        start_acc(1'b1, 16'h1800, 8'h00);
        checks++; if (DB_I !== 8'hFF) $display("FAIL open_dbi: got %h want ff", DB_I); else passed++;
        checks++; if (WAITB !== 1'b1) $display("FAIL open_waitb: got %b want 1", WAITB); else passed++;
        release_bus();
        checks++; if (req_cycles !== 0) $display("FAIL open_no_req: got %0d want 0", req_cycles); else passed++;
    endtask

    task automatic test_reset_mid_ext();
        start_acc(1'b1, 16'h2000, 8'h00);
        tick();
        RESET = 1'b1; RDB = 1'b1;
        tick();
        RESET = 1'b0;
        checks++; if (MEM_REQ !== 1'b0) $display("FAIL rst_ext_req: got %b want 0", MEM_REQ); else passed++;
        checks++; if (WAITB !== 1'b1) $display("FAIL rst_ext_waitb: got %b want 1", WAITB); else passed++;
        checks++; if (DB_I !== 8'hFF) $display("FAIL rst_ext_dbi: got %h want ff", DB_I); else passed++;
        MEM_DI = 8'h55; MEM_ACK = 1'b1;
        tick();
        MEM_ACK = 1'b0;
        checks++; if (DB_I !== 8'hFF) $display("FAIL stray_ack_dbi: got %h want ff", DB_I); else passed++;
        checks++; if (dut.state !== 2'd0) $display("FAIL stray_ack_state: got %0d want 0", dut.state); else passed++;
    endtask

    task automatic test_back_to_back();
        req_starts = 0;
        A = 16'h2000; RDB = 1'b0; WRB = 1'b1;
        for (int i = 0; i < 9; i++) begin
            CP1_POSEDGE = (i % 3 == 0);
            MEM_ACK = MEM_REQ;
            MEM_DI = 8'h66;
            tick();
        end
        CP1_POSEDGE = 1'b0; MEM_ACK = 1'b0;
        checks++; if (req_starts !== 1) $display("FAIL held_strobe_reqs: got %0d want 1", req_starts); else passed++;
        checks++; if (dut.state !== 2'd3) $display("FAIL held_strobe_state: got %0d want 3", dut.state); else passed++;
        release_bus();
        checks++; if (dut.state !== 2'd0) $display("FAIL release_state: got %0d want 0", dut.state); else passed++;
    endtask

    initial begin
        RESET = 1'b1; CP1_POSEDGE = 1'b0; A = 16'h0000; DB_O = 8'h00;
        RDB = 1'b1; WRB = 1'b1; MEM_DI = 8'h00; MEM_ACK = 1'b0;
        test_reset();
        test_iram();
        test_ext_read();
        test_ext_timeout();
        test_ack_priority();
        test_open_and_both_low();
        test_decode();
        test_reset_mid_ext();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 SHALL have parameter IRAM_BASE, default 16'hFF80, which is the first address of the 128-byte internal RAM window (window runs IRAM_BASE..IRAM_BASE+127).
REQ-002 SHALL have parameter TIMEOUT, default 255, which is the maximum number of CLK cycles to wait for MEM_ACK before an external access is aborted.
REQ-003 Ports (name, direction, width, meaning):
- CLK, in, 1: system clock.
- RESET, in, 1: reset; one clock; reset is synchronous and active-high.
- CP1_POSEDGE, in, 1: CPU phase-1 rising-edge enable.
- A, in, 16: CPU address.
- DB_O, in, 8: CPU write data.
- RDB, in, 1: read strobe, active-low.
- WRB, in, 1: write strobe, active-low.
- DB_I, out, 8: read data returned to the CPU.
- WAITB, out, 1: CPU stall, active-low.
- MEM_REQ, out, 1: external memory request.
- MEM_WE, out, 1: external memory write enable.
- MEM_SEL, out, 2: external region select.
- MEM_A, out, 15: external memory offset.
- MEM_DO, out, 8: external write data.
- MEM_DI, in, 8: external read data.
- MEM_ACK, in, 1: external completion strobe, 1-cycle pulse.

Function
REQ-004 Address decode SHALL be as follows, with MEM_A = A minus the region base:
- IRAM_BASE..+127: internal RAM (IRAM).
- 0000-0FFF: BOOT, MEM_SEL=0.
- 2000-3FFF: VRAM, MEM_SEL=1.
- 8000 up to IRAM_BASE-1: CART, MEM_SEL=2.
- All other addresses: OPEN bus.
REQ-005 An access SHALL start on a CLK cycle where CP1_POSEDGE=1, exactly one of RDB/WRB is low, and the state is IDLE; A and DB_O SHALL be latched on that cycle.
REQ-006 RDB and WRB both low SHALL NOT start an access; the state SHALL remain IDLE.
REQ-007 The state machine SHALL have the states IDLE, IRAM, EXT, HOLD.
REQ-008 State transitions SHALL be:
- IDLE to IRAM on a start that decodes to IRAM.
- IDLE to EXT on a start that decodes to BOOT, VRAM or CART.
- IDLE to HOLD on a start that decodes to OPEN.
- IRAM to HOLD after one cycle.
- EXT to HOLD on MEM_ACK or on timeout.
- HOLD to IDLE on the first cycle where RDB and WRB are both high.
REQ-009 IRAM read: DB_I SHALL equal the RAM byte on the cycle after the start and SHALL hold that value through HOLD. IRAM write: the RAM byte SHALL be updated on the cycle after the start.
REQ-010 EXT state:
- MEM_REQ=1 on every EXT cycle, starting the cycle after the start.
- MEM_WE=1 for a write.
- MEM_SEL, MEM_A and MEM_DO stable for the whole of EXT.
- WAITB=0 throughout EXT.
REQ-011 When MEM_ACK=1 in EXT, then on the following cycle:
- for a read, DB_I SHALL equal the MEM_DI value sampled on the ack cycle;
- MEM_REQ SHALL be 0, WAITB SHALL be 1, and the state SHALL be HOLD.
REQ-012 MEM_ACK outside the EXT state SHALL be ignored and SHALL have no effect.
REQ-013 Timeout: an 8-bit counter SHALL clear on entry to EXT and increment on each EXT cycle. When it reaches TIMEOUT with no ack, the access SHALL be aborted: DB_I=8'hFF, write dropped, MEM_REQ=0, WAITB=1, state HOLD.
REQ-014 An ack arriving on the same cycle the counter reaches TIMEOUT SHALL take priority over the timeout.
REQ-015 OPEN read SHALL return DB_I=8'hFF; OPEN write SHALL be discarded; neither SHALL assert MEM_REQ.
REQ-016 No second access SHALL start until the strobes have been released, so a strobe held low across several CP1 edges produces exactly one access.
REQ-017 IRAM address arithmetic SHALL use A[6:0] only; MEM_A SHALL use 15 bits, and the subtraction SHALL not wrap across regions.

Reset
REQ-018 While RESET=1, the block SHALL set: state IDLE, MEM_REQ=0, MEM_WE=0, WAITB=1, DB_I=8'hFF, timeout counter 0. IRAM contents SHALL be undefined and SHALL NOT be cleared.
REQ-019 RESET asserted mid-EXT SHALL drop MEM_REQ on the next cycle, and a later MEM_ACK for that request SHALL be ignored.

Verification
REQ-020 IRAM write A=FF85 DB_O=5A, then IRAM read A=FF85 -> DB_I=5A one cycle after the start; MEM_REQ never asserted.
REQ-021 Read A=2010 with MEM_ACK three cycles later and MEM_DI=C3 -> MEM_SEL=1, MEM_A=0010, MEM_REQ and WAITB=0 for 3 cycles, then DB_I=C3 and WAITB=1.
REQ-022 Write A=9000 DB_O=11 with no ack and TIMEOUT=4 -> MEM_REQ high for 4 cycles and then dropped, WAITB returns to 1.
REQ-023 RDB and WRB both low at CP1 -> state stays IDLE; read of A=1800 (OPEN) -> DB_I=FF with no request.
REQ-024 RESET pulsed during EXT, then stray MEM_ACK -> MEM_REQ=0, WAITB=1, DB_I=FF, state IDLE; RDB held low for 3 CP1 edges -> exactly one request.
